// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared ids, limits and helpers for the data-memory port arbiter
package arm_mem_pkg;

   typedef logic mid_t;

   localparam mid_t MID_CPU = 1'b0;
   localparam mid_t MID_AUX = 1'b1;

   localparam int RD_LAT_MAX = 4;
   localparam int STREAK_W   = 4;

   localparam logic [STREAK_W-1:0] STREAK_SAT = '1;

   function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] s);
      return (s == STREAK_SAT) ? s : s + 4'd1;
   endfunction

endpackage

// File: rtl/rd_return_pipe.sv
// rtl/rd_return_pipe.sv - DEPTH-stage {valid,id} delay line that tags read returns with their issuer
module rd_return_pipe
   import arm_mem_pkg::*;
#(
   parameter int DEPTH = 1
)
(
   input  logic clk,
   input  logic reset,
   input  logic i_push_valid,
   input  mid_t i_push_id,
   output logic o_valid,
   output mid_t o_id
);

   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_id;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
         r_id    <= '0;
      end else begin
         r_valid[0] <= i_push_valid;
         r_id[0]    <= i_push_id;
         for (int i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_id[i]    <= r_id[i-1];
         end
      end
   end

   assign o_valid = r_valid[DEPTH-1];
   assign o_id    = r_id[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-master arbiter for a single-port data memory with
// bounded-hold priority and issuer-tagged read returns
module mem_port_arbiter
   import arm_mem_pkg::*;
#(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int RD_LAT   = 1,
   parameter int MAX_HOLD = 4
)
(
   input  logic            clk,
   input  logic            reset,

   input  logic            m0_req,
   input  logic            m0_we,
   input  logic [AW-1:0]   m0_addr,
   input  logic [DW-1:0]   m0_wdata,
   input  logic [DW/8-1:0] m0_be,
   output logic            m0_gnt,
   output logic            m0_rvalid,
   output logic [DW-1:0]   m0_rdata,
   output logic            m0_stall,

   input  logic            m1_req,
   input  logic            m1_we,
   input  logic [AW-1:0]   m1_addr,
   input  logic [DW-1:0]   m1_wdata,
   input  logic [DW/8-1:0] m1_be,
   output logic            m1_gnt,
   output logic            m1_rvalid,
   output logic [DW-1:0]   m1_rdata,

   output logic            mem_en,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_be,
   input  logic [DW-1:0]   mem_rdata
);

   localparam logic [STREAK_W-1:0] HOLD_LIM = STREAK_W'(MAX_HOLD);

   mid_t                r_prio;
   logic [STREAK_W-1:0] r_streak;
   logic [DW-1:0]       r_m0_rdata;
   logic [DW-1:0]       r_m1_rdata;

   logic                w_m0_gnt;
   logic                w_m1_gnt;
   logic                w_any_gnt;
   mid_t                w_gnt_id;
   logic                w_other_req;
   logic [STREAK_W-1:0] w_streak_next;
   logic                w_cap;
   logic                w_rd_push;
   logic                w_ret_valid;
   mid_t                w_ret_id;

   always @(posedge clk) begin
      assert (RD_LAT >= 1 && RD_LAT <= RD_LAT_MAX)
         else $error("mem_port_arbiter: RD_LAT=%0d outside 1..%0d", RD_LAT, RD_LAT_MAX);
      assert (MAX_HOLD >= 1 && MAX_HOLD <= 15)
         else $error("mem_port_arbiter: MAX_HOLD=%0d outside 1..15", MAX_HOLD);
   end

   // Grants are forced low while reset is held so nothing reaches memory mid-reset.
   assign w_m0_gnt  = reset & m0_req & (~m1_req | (r_prio == MID_CPU));
   assign w_m1_gnt  = reset & m1_req & (~m0_req | (r_prio == MID_AUX));
   assign w_any_gnt = w_m0_gnt | w_m1_gnt;
   assign w_gnt_id  = w_m1_gnt ? MID_AUX : MID_CPU;

   assign w_other_req   = w_m1_gnt ? m0_req : m1_req;
   assign w_streak_next = (w_gnt_id == r_prio) ? streak_inc(r_streak) : STREAK_W'(1);
   // ">=" also catches a streak built up while uncontended, so the newcomer waits one grant at most.
   assign w_cap         = w_other_req & (w_streak_next >= HOLD_LIM);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prio   <= MID_CPU;
         r_streak <= '0;
      end else if (w_any_gnt) begin
         if (w_cap) begin
            r_prio   <= ~w_gnt_id;
            r_streak <= '0;
         end else begin
            r_prio   <= w_gnt_id;
            r_streak <= w_streak_next;
         end
      end
   end

   assign mem_en    = w_any_gnt;
   assign mem_we    = w_any_gnt & (w_m1_gnt ? m1_we : m0_we);
   assign mem_addr  = w_m1_gnt ? m1_addr  : m0_addr;
   assign mem_wdata = w_m1_gnt ? m1_wdata : m0_wdata;
   assign mem_be    = w_m1_gnt ? m1_be    : m0_be;

   assign w_rd_push = w_any_gnt & ~mem_we;

   rd_return_pipe #(
      .DEPTH (RD_LAT)
   ) u_rd_return_pipe (
      .clk          (clk),
      .reset        (reset),
      .i_push_valid (w_rd_push),
      .i_push_id    (w_gnt_id),
      .o_valid      (w_ret_valid),
      .o_id         (w_ret_id)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_m0_rdata <= '0;
         r_m1_rdata <= '0;
      end else if (w_ret_valid) begin
         if (w_ret_id == MID_CPU) r_m0_rdata <= mem_rdata;
         else                     r_m1_rdata <= mem_rdata;
      end
   end

   assign m0_gnt    = w_m0_gnt;
   assign m1_gnt    = w_m1_gnt;
   assign m0_stall  = m0_req & ~w_m0_gnt;
   assign m0_rvalid = w_ret_valid & (w_ret_id == MID_CPU);
   assign m1_rvalid = w_ret_valid & (w_ret_id == MID_AUX);
   assign m0_rdata  = m0_rvalid ? mem_rdata : r_m0_rdata;
   assign m1_rdata  = m1_rvalid ? mem_rdata : r_m1_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench; dut_a uses RD_LAT=1, dut_b uses RD_LAT=3
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;
   logic [3:0]  m0_be, m1_be;

   logic        a_m0_gnt, a_m0_rvalid, a_m0_stall, a_m1_gnt, a_m1_rvalid, a_mem_en, a_mem_we;
   logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata;
   logic [3:0]  a_mem_be;
   logic        b_m0_gnt, b_m0_rvalid, b_m0_stall, b_m1_gnt, b_m1_rvalid, b_mem_en, b_mem_we;
   logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata;
   logic [3:0]  b_mem_be;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .MAX_HOLD(4)) dut_a (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
      .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata), .m0_stall(a_m0_stall),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
      .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_be(a_mem_be), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .MAX_HOLD(4)) dut_b (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
      .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata), .m0_stall(b_m0_stall),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
      .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_be(b_mem_be), .mem_rdata(mem_rdata)
   );

   task automatic idle_inputs();
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
      mem_rdata = 32'hFFFF_FFFF;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 0;
      idle_inputs();
      repeat (2) @(negedge clk);
      reset = 1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 0;
      m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1;
      #1;
      n_chk++; if (a_m0_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_m0_gnt: got %b want 0", a_m0_gnt); end
      n_chk++; if (a_m1_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_m1_gnt: got %b want 0", a_m1_gnt); end
      n_chk++; if (a_mem_en !== 1'b0 || a_mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en_we: got %b%b want 00", a_mem_en, a_mem_we); end
      n_chk++; if (a_m0_rvalid !== 1'b0 || b_m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b%b want 00", a_m0_rvalid, b_m1_rvalid); end
      n_chk++; if (a_m0_rdata !== 32'h0 || b_m1_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h %h want 0", a_m0_rdata, b_m1_rdata); end
      idle_inputs();
      @(negedge clk);
      reset = 1;
   endtask

   task automatic test_single_read();
      do_reset();
      @(negedge clk);
      m0_req = 1; m0_we = 0; m0_addr = 32'h100;
      #1;
      n_chk++; if (a_m0_gnt !== 1'b1 || a_m1_gnt !== 1'b0) begin n_fail++; $display("FAIL sr_gnt: got %b%b want 10", a_m0_gnt, a_m1_gnt); end
      n_chk++; if (a_mem_en !== 1'b1 || a_mem_we !== 1'b0 || a_mem_addr !== 32'h100) begin n_fail++; $display("FAIL sr_mem: got en=%b we=%b addr=%h want 1 0 100", a_mem_en, a_mem_we, a_mem_addr); end
      n_chk++; if (a_m0_stall !== 1'b0) begin n_fail++; $display("FAIL sr_stall: got %b want 0", a_m0_stall); end
      @(negedge clk);
      idle_inputs();
      mem_rdata = 32'hA5A5_0100;
      #1;
      n_chk++; if (a_m0_rvalid !== 1'b1 || a_m0_rdata !== 32'hA5A5_0100) begin n_fail++; $display("FAIL sr_ret: got v=%b d=%h want 1 a5a50100", a_m0_rvalid, a_m0_rdata); end
      n_chk++; if (a_m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL sr_m1_rvalid: got %b want 0", a_m1_rvalid); end
      @(negedge clk);
      mem_rdata = 32'h0BAD_F00D;
      #1;
      n_chk++; if (a_m0_rvalid !== 1'b0 || a_m0_rdata !== 32'hA5A5_0100) begin n_fail++; $display("FAIL sr_hold: got v=%b d=%h want 0 a5a50100", a_m0_rvalid, a_m0_rdata); end
   endtask

   task automatic test_contention();
      logic exp0;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         m0_req = 1; m0_we = 1; m0_wdata = 32'h1111_1111; m0_be = 4'hF;
         m1_req = 1; m1_we = 1; m1_wdata = 32'h2222_2222; m1_be = 4'hF;
         #1;
         exp0 = (c < 4) || (c >= 8);
         n_chk++; if (a_m0_gnt !== exp0 || a_m1_gnt !== !exp0) begin n_fail++; $display("FAIL cont_gnt c%0d: got %b%b want %b%b", c, a_m0_gnt, a_m1_gnt, exp0, !exp0); end
         n_chk++; if (a_m0_stall !== !exp0) begin n_fail++; $display("FAIL cont_stall c%0d: got %b want %b", c, a_m0_stall, !exp0); end
         n_chk++; if (a_mem_wdata !== (exp0 ? 32'h1111_1111 : 32'h2222_2222)) begin n_fail++; $display("FAIL cont_wdata c%0d: got %h", c, a_mem_wdata); end
      end
      idle_inputs();
   endtask

   task automatic test_interleave();
      logic rv0, rv1;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         idle_inputs();
         case (c)
            0: begin m0_req = 1; m0_addr = 32'h10; end
            1: begin m1_req = 1; m1_addr = 32'h20; end
            2: begin m0_req = 1; m0_addr = 32'h30; end
            3: mem_rdata = 32'hD000_0010;
            4: mem_rdata = 32'hD000_0020;
            5: mem_rdata = 32'hD000_0030;
            default: ;
         endcase
         #1;
         rv0 = (c == 3) || (c == 5);
         rv1 = (c == 4);
         n_chk++; if (b_m0_rvalid !== rv0 || b_m1_rvalid !== rv1) begin n_fail++; $display("FAIL il_rvalid c%0d: got %b%b want %b%b", c, b_m0_rvalid, b_m1_rvalid, rv0, rv1); end
         if (c == 3) begin
            n_chk++; if (b_m0_rdata !== 32'hD000_0010) begin n_fail++; $display("FAIL il_d0: got %h want d0000010", b_m0_rdata); end
         end
         if (c == 4) begin
            n_chk++; if (b_m1_rdata !== 32'hD000_0020 || b_m0_rdata !== 32'hD000_0010) begin n_fail++; $display("FAIL il_d1: got %h %h want d0000020 d0000010", b_m1_rdata, b_m0_rdata); end
         end
         if (c == 6) begin
            n_chk++; if (b_m0_rdata !== 32'hD000_0030 || b_m1_rdata !== 32'hD000_0020) begin n_fail++; $display("FAIL il_final: got %h %h want d0000030 d0000020", b_m0_rdata, b_m1_rdata); end
         end
      end
   endtask

   task automatic test_write();
      do_reset();
      @(negedge clk);
      m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'hDEAD_BEEF; m1_be = 4'b0011;
      #1;
      n_chk++; if (a_m1_gnt !== 1'b1 || a_m0_gnt !== 1'b0) begin n_fail++; $display("FAIL wr_gnt: got %b%b want 01", a_m0_gnt, a_m1_gnt); end
      n_chk++; if (a_mem_en !== 1'b1 || a_mem_we !== 1'b1 || a_mem_be !== 4'b0011) begin n_fail++; $display("FAIL wr_ctl: got en=%b we=%b be=%b want 1 1 0011", a_mem_en, a_mem_we, a_mem_be); end
      n_chk++; if (a_mem_addr !== 32'h40 || a_mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_data: got %h %h want 40 deadbeef", a_mem_addr, a_mem_wdata); end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         idle_inputs();
         #1;
         n_chk++; if ({a_m0_rvalid, a_m1_rvalid, b_m0_rvalid, b_m1_rvalid, a_mem_en} !== 5'b0) begin n_fail++; $display("FAIL wr_quiet c%0d: got %b%b%b%b en=%b want 0", c, a_m0_rvalid, a_m1_rvalid, b_m0_rvalid, b_m1_rvalid, a_mem_en); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_d;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         idle_inputs();
         if (c < 3) begin m0_req = 1; m0_addr = 32'h100 + 32'(4 * c); end
         if (c == 3) begin m1_req = 1; m1_we = 1; m1_addr = 32'h80; m1_wdata = 32'h5555_AAAA; m1_be = 4'hF; end
         if (c >= 1 && c <= 3) mem_rdata = 32'hE000_0100 + 32'(4 * (c - 1));
         exp_d = 32'hE000_0100 + 32'(4 * (c - 1));
         #1;
         if (c < 3) begin
            n_chk++; if (a_m0_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt c%0d: got %b want 1", c, a_m0_gnt); end
         end
         if (c >= 1 && c <= 3) begin
            n_chk++; if (a_m0_rvalid !== 1'b1 || a_m0_rdata !== exp_d) begin n_fail++; $display("FAIL b2b_ret c%0d: got v=%b d=%h want 1 %h", c, a_m0_rvalid, a_m0_rdata, exp_d); end
         end
         if (c == 3) begin
            n_chk++; if (a_m1_gnt !== 1'b1 || a_mem_we !== 1'b1 || a_m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_wr_ret: got gnt=%b we=%b m1rv=%b want 1 1 0", a_m1_gnt, a_mem_we, a_m1_rvalid); end
         end
         if (c == 4) begin
            n_chk++; if (a_m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", a_m0_rvalid); end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic exp0;
      do_reset();
      @(negedge clk);
      m0_req = 1; m0_addr = 32'h200;
      @(negedge clk);
      idle_inputs();
      reset = 0;
      #1;
      n_chk++; if (a_m0_rvalid !== 1'b0 || b_m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rm_in_reset: got %b%b want 00", a_m0_rvalid, b_m0_rvalid); end
      @(negedge clk);
      reset = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         n_chk++; if ({a_m0_rvalid, a_m1_rvalid, b_m0_rvalid, b_m1_rvalid} !== 4'b0) begin n_fail++; $display("FAIL rm_stale c%0d: got %b%b%b%b want 0000", c, a_m0_rvalid, a_m1_rvalid, b_m0_rvalid, b_m1_rvalid); end
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1;
         #1;
         exp0 = (c < 4);
         n_chk++; if (b_m0_gnt !== exp0 || b_m1_gnt !== !exp0) begin n_fail++; $display("FAIL rm_prio c%0d: got %b%b want %b%b", c, b_m0_gnt, b_m1_gnt, exp0, !exp0); end
      end
      idle_inputs();
   endtask

   task automatic test_sticky();
      logic exp1;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         m1_req = 1; m1_we = 1;
         m0_req = (c >= 6); m0_we = 1;
         #1;
         exp1 = (c < 7) || (c == 11);
         n_chk++; if (a_m1_gnt !== exp1 || a_m0_gnt !== (!exp1)) begin n_fail++; $display("FAIL sticky c%0d: got m0=%b m1=%b want m1=%b", c, a_m0_gnt, a_m1_gnt, exp1); end
      end
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 0;
      idle_inputs();
      test_reset();
      test_single_read();
      test_contention();
      test_interleave();
      test_write();
      test_back_to_back();
      test_reset_mid();
      test_sticky();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
